// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, LSB-first data, optional parity, stop, timed by rising edges of baud16.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | line high, tx_ready asserted, waiting for tx_valid
// S_START  | start bit (txd low) for OVERSAMPLE ticks
// S_DATA   | data bits, shift register bit 0 on the line
// S_PARITY | even parity of the latched byte (parity build only)
// S_STOP   | line high for STOP_BITS bit periods, tx_done on the last tick
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud16,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 baud16_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 tick;
    logic                 bit_end;
    logic                 done_c;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_comb begin
        tick       = baud16 & ~baud16_q;
        bit_end    = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        // The tick counter only runs inside a frame, so a tick coinciding with accept is dropped.
        if (tick && (state_q != S_IDLE)) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d    = S_START;
                    shift_d    = tx_data;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        done_c    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // txd is registered from the next state so the line changes on the bit-boundary edge.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud16_q   <= 1'b0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud16_q   <= baud16;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign txd      = txd_q;
    assign tx_done  = done_c & ~rst;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frames are compared as run-length level/duration lists
// derived from the byte value and frame format, with baud16 toggling every 2 clk (one bit = 64 clk).
module tb_uart_tx_ctrl;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLK    = 4 * OVERSAMPLE;
    localparam int TOL        = 4;
    localparam int LIMIT      = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud16 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd, busy, tx_done;

    int  nvec = 0;
    int  nerr = 0;
    bit  baud_run = 1'b1;
    int  bcnt = 0;

    int  exp_lvl[$];
    int  exp_len[$];
    int  exp_nbits;
    int  cap_lvl[$];
    int  cap_len[$];
    int  cap_k;
    bit  cap_to;
    logic cap_txd1, cap_busy1, cap_rdy1;

    uart_tx_ctrl #(
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .baud16  (baud16),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .txd     (txd),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // baud16 changes 2 ns after the rising edge, well clear of sampling at either edge
    always begin
        @(posedge clk);
        #2;
        if (!baud_run) begin
            baud16 = 1'b0;
            bcnt   = 0;
        end else begin
            bcnt++;
            if (bcnt == 2) begin
                baud16 = ~baud16;
                bcnt   = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no summary by 500000 ns, want finish");
        $fatal(1, "watchdog expired");
    end

    // Reference frame: list of line levels per bit, merged into (level, clk duration) runs.
    task automatic build_expected(input logic [7:0] b);
        int bits[$];
        bits.push_back(0);
        for (int i = 0; i < DATA_BITS; i++) bits.push_back(int'(b[i]));
`ifdef UART_TX_PARITY_EN
        bits.push_back(int'(^b));
`endif
        for (int i = 0; i < STOP_BITS; i++) bits.push_back(1);
        exp_nbits = bits.size();
        exp_lvl.delete();
        exp_len.delete();
        for (int i = 0; i < bits.size(); i++) begin
            if (i > 0 && bits[i] == bits[i-1]) exp_len[exp_len.size()-1] += BIT_CLK;
            else begin
                exp_lvl.push_back(bits[i]);
                exp_len.push_back(BIT_CLK);
            end
        end
    endtask

    task automatic wait_ready_accept(output bit to);
        int n = 0;
        while (tx_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        to = (n >= LIMIT);
        @(posedge clk);
    endtask

    // Called right after the accepting edge; samples every negedge until tx_done.
    task automatic capture(input bit drop_valid, input bit chg, input logic [7:0] new_data);
        int k = 0;
        cap_lvl.delete();
        cap_len.delete();
        cap_to = 1'b0;
        cap_k  = 0;
        forever begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                cap_txd1  = txd;
                cap_busy1 = busy;
                cap_rdy1  = tx_ready;
                if (drop_valid) tx_valid = 1'b0;
                if (chg) tx_data = new_data;
            end
            if (cap_lvl.size() == 0 || cap_lvl[cap_lvl.size()-1] != int'(txd)) begin
                cap_lvl.push_back(int'(txd));
                cap_len.push_back(1);
            end else begin
                cap_len[cap_len.size()-1] += 1;
            end
            if (tx_done === 1'b1) begin
                cap_k = k;
                break;
            end
            if (k >= LIMIT) begin
                cap_to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit to;
        bit bad = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({tx_done, tx_ready, busy, txd} !== 4'b0101) begin
            nerr++;
            $display("FAIL reset_init: got done/rdy/busy/txd=%b, want 0101", {tx_done, tx_ready, busy, txd});
        end
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        wait_ready_accept(to);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (150) @(negedge clk);
        nvec++;
        if (to || busy !== 1'b1) begin
            nerr++;
            $display("FAIL reset_midframe_busy: got busy=%b timeout=%0d, want busy=1", busy, to);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL reset_hold: got done/txd/busy off during reset, want 0/1/0");
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({tx_done, tx_ready, busy, txd} !== 4'b0101) begin
            nerr++;
            $display("FAIL reset_release: got done/rdy/busy/txd=%b, want 0101", {tx_done, tx_ready, busy, txd});
        end
    endtask

    task automatic test_single_frame(input logic [7:0] b, input string nm);
        bit to;
        build_expected(b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        wait_ready_accept(to);
        nvec++;
        if (to) begin
            nerr++;
            $display("FAIL %s accept: got tx_ready never high, want accept", nm);
        end
        capture(1'b1, 1'b0, 8'h00);
        nvec++;
        if (cap_to) begin
            nerr++;
            $display("FAIL %s done_timeout: got no tx_done in %0d clk, want one", nm, LIMIT);
        end
        nvec++;
        if ({cap_txd1, cap_busy1, cap_rdy1} !== 3'b010) begin
            nerr++;
            $display("FAIL %s first_cycle: got txd/busy/rdy=%b, want 010", nm, {cap_txd1, cap_busy1, cap_rdy1});
        end
        nvec++;
        if (cap_lvl.size() != exp_lvl.size()) begin
            nerr++;
            $display("FAIL %s run_count: got %0d, want %0d (byte %h)", nm, cap_lvl.size(), exp_lvl.size(), b);
        end else begin
            for (int i = 0; i < exp_lvl.size(); i++) begin
                nvec++;
                if (cap_lvl[i] != exp_lvl[i] || cap_len[i] < exp_len[i] - TOL || cap_len[i] > exp_len[i] + TOL) begin
                    nerr++;
                    $display("FAIL %s run%0d: got lvl=%0d len=%0d, want lvl=%0d len=%0d", nm, i, cap_lvl[i], cap_len[i], exp_lvl[i], exp_len[i]);
                end
            end
        end
        nvec++;
        if (cap_k < exp_nbits * BIT_CLK - TOL || cap_k > exp_nbits * BIT_CLK + TOL) begin
            nerr++;
            $display("FAIL %s done_time: got %0d clk, want %0d", nm, cap_k, exp_nbits * BIT_CLK);
        end
        @(negedge clk);
        nvec++;
        if ({tx_done, tx_ready, busy, txd} !== 4'b0101) begin
            nerr++;
            $display("FAIL %s after_done: got done/rdy/busy/txd=%b, want 0101", nm, {tx_done, tx_ready, busy, txd});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2];
        bit to;
        bytes[0] = 8'hA3;
        bytes[1] = 8'h0F;
        @(negedge clk);
        tx_data  = bytes[0];
        tx_valid = 1'b1;
        wait_ready_accept(to);
        nvec++;
        if (to) begin
            nerr++;
            $display("FAIL b2b accept0: got tx_ready never high, want accept");
        end
        for (int f = 0; f < 2; f++) begin
            build_expected(bytes[f]);
            capture(1'b0, f == 0, bytes[1]);
            if (f == 1) tx_valid = 1'b0;
            nvec++;
            if (cap_to || {cap_txd1, cap_busy1, cap_rdy1} !== 3'b010) begin
                nerr++;
                $display("FAIL b2b frame%0d_start: got txd/busy/rdy=%b timeout=%0d, want 010", f, {cap_txd1, cap_busy1, cap_rdy1}, cap_to);
            end
            nvec++;
            if (cap_lvl.size() != exp_lvl.size()) begin
                nerr++;
                $display("FAIL b2b frame%0d_runs: got %0d, want %0d", f, cap_lvl.size(), exp_lvl.size());
            end else begin
                for (int i = 0; i < exp_lvl.size(); i++) begin
                    nvec++;
                    if (cap_lvl[i] != exp_lvl[i] || cap_len[i] < exp_len[i] - TOL || cap_len[i] > exp_len[i] + TOL) begin
                        nerr++;
                        $display("FAIL b2b frame%0d_run%0d: got lvl=%0d len=%0d, want lvl=%0d len=%0d", f, i, cap_lvl[i], cap_len[i], exp_lvl[i], exp_len[i]);
                    end
                end
            end
            if (f == 0) begin
                @(negedge clk);
                nvec++;
                if ({tx_done, tx_ready, busy} !== 3'b010) begin
                    nerr++;
                    $display("FAIL b2b gap: got done/rdy/busy=%b, want 010", {tx_done, tx_ready, busy});
                end
                @(posedge clk);
            end
        end
        repeat (5) @(negedge clk);
        nvec++;
        if ({tx_ready, busy, txd} !== 3'b101) begin
            nerr++;
            $display("FAIL b2b end_idle: got rdy/busy/txd=%b, want 101", {tx_ready, busy, txd});
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            test_single_frame(r, "random");
        end
    endtask

    task automatic test_reset_data_bit3();
        bit to;
        int n = 0;
        bit bad = 1'b0;
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        wait_ready_accept(to);
        @(negedge clk);
        tx_valid = 1'b0;
        while (txd !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3 * BIT_CLK + 30) @(negedge clk);
        nvec++;
        if (to || n >= 200 || busy !== 1'b1 || txd !== 1'b1) begin
            nerr++;
            $display("FAIL rst_bit3 pre: got busy=%b txd=%b, want 1 1", busy, txd);
        end
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if ({tx_done, tx_ready, busy, txd} !== 4'b0101) begin
            nerr++;
            $display("FAIL rst_bit3 abort: got done/rdy/busy/txd=%b, want 0101", {tx_done, tx_ready, busy, txd});
        end
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || txd !== 1'b1) bad = 1'b1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL rst_bit3 quiet: got tx_done or txd low after abort, want idle line");
        end
        test_single_frame(8'h81, "after_reset");
    endtask

    task automatic test_stall();
        bit to;
        int n = 0;
        int trans = 0;
        int c2 = 0;
        logic prev, hold;
        bit bad = 1'b0;
        build_expected(8'h55);
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        wait_ready_accept(to);
        @(negedge clk);
        tx_valid = 1'b0;
        prev = txd;
        while (trans < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (txd !== prev) trans++;
            prev = txd;
        end
        c2 = 1;
        repeat (29) begin
            @(negedge clk);
            c2++;
        end
        baud_run = 1'b0;
        hold = txd;
        repeat (1000) begin
            @(negedge clk);
            c2++;
            if (txd !== hold || busy !== 1'b1 || tx_done !== 1'b0) bad = 1'b1;
        end
        nvec++;
        if (to || trans < 3 || bad) begin
            nerr++;
            $display("FAIL stall hold: got line or state moved (trans=%0d), want frozen", trans);
        end
        baud_run = 1'b1;
        capture(1'b0, 1'b0, 8'h00);
        nvec++;
        if (cap_to || cap_lvl.size() != exp_lvl.size() - 3) begin
            nerr++;
            $display("FAIL stall runs: got %0d runs timeout=%0d, want %0d", cap_lvl.size(), cap_to, exp_lvl.size() - 3);
        end else begin
            nvec++;
            if (cap_lvl[0] != exp_lvl[3] || c2 + cap_len[0] < BIT_CLK + 1000 - 2 * TOL || c2 + cap_len[0] > BIT_CLK + 1000 + 2 * TOL) begin
                nerr++;
                $display("FAIL stall bit2: got lvl=%0d len=%0d, want lvl=%0d len=%0d", cap_lvl[0], c2 + cap_len[0], exp_lvl[3], BIT_CLK + 1000);
            end
            for (int i = 1; i < cap_lvl.size(); i++) begin
                nvec++;
                if (cap_lvl[i] != exp_lvl[i+3] || cap_len[i] < exp_len[i+3] - TOL || cap_len[i] > exp_len[i+3] + TOL) begin
                    nerr++;
                    $display("FAIL stall run%0d: got lvl=%0d len=%0d, want lvl=%0d len=%0d", i, cap_lvl[i], cap_len[i], exp_lvl[i+3], exp_len[i+3]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(8'h55, "byte55");
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_single_frame(8'h07, "parity07");
        test_single_frame(8'h03, "parity03");
`endif
        test_random();
        test_reset_data_bit3();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller driven by the 16x-baud sampling clock from the team's UART clock divider. It turns that square wave into single-cycle ticks and sequences the frame (start, data LSB-first, optional parity, stop) on `txd`. A valid/ready handshake lets the upstream byte source hand it one byte at a time. It runs in the system clock domain alongside the divider and the UART receiver.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- STOP_BITS, 1, number of stop bits (1 or 2).
- OVERSAMPLE, 16, ticks per bit; must match the divider's 16x rate.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous reset, active-high.
- baud16, in, 1, 16x-baud square wave from the clock divider (synchronous to clk).
- tx_data, in, DATA_BITS, byte to send.
- tx_valid, in, 1, tx_data is valid.
- tx_ready, out, 1, controller can accept a byte.
- txd, out, 1, serial line; idles high.
- busy, out, 1, frame in progress.
- tx_done, out, 1, one-cycle pulse when the last stop bit completes.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high; it takes effect on the `clk` edge where it is high.
- Reset values: state=IDLE, txd=1, tx_ready=1, busy=0, tx_done=0, tick counter=0, bit counter=0, shift register=0.
- Tick generation:
  - baud16 is registered once into baud16_d.
  - tick = baud16 & ~baud16_d, so there is one tick per baud16 rising edge.
  - All timing advances only on tick.
  - If baud16 stalls, the FSM freezes and txd holds its value.
- Handshake:
  - Accept happens when tx_valid && tx_ready are both high at a clk edge.
  - On accept: latch tx_data into the shift register, state goes to START, tick counter=0, and on the next cycle tx_ready=0, busy=1, txd=0.
  - tx_valid is ignored while tx_ready=0.
  - tx_data may change after accept with no effect on the frame in progress.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each bit lasts OVERSAMPLE ticks. The tick counter increments on tick; on the tick where counter==OVERSAMPLE-1, it wraps to 0 and the FSM advances to the next bit.
  - The first bit period after accept includes up to one partial tick interval.
- DATA:
  - txd = shift register bit 0. On each bit boundary, shift right and increment the bit counter.
  - Leave DATA after DATA_BITS bits.
- STOP:
  - txd=1 for STOP_BITS*OVERSAMPLE ticks.
  - On the final tick: tx_done=1 for exactly one cycle, state=IDLE, and on the next cycle tx_ready=1 and busy=0.
- Back-to-back frames:
  - The earliest next accept is the cycle after tx_done.
  - txd stays 1 between frames for at least the stop duration.
- tx_ready is combinationally equal to (state==IDLE).
- Reset mid-frame: abort on that edge; txd=1 next cycle; no tx_done pulse.
- Simultaneous tick and accept in IDLE: the accept wins. The tick is not counted; counting starts from the next tick.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and lasts OVERSAMPLE ticks. txd carries the even-parity bit, i.e. the XOR of the data bits latched at accept. Frame length is (1+DATA_BITS+1+STOP_BITS) bits.
- Undefined: no PARITY state; DATA goes straight to STOP.

Test Plan:
All timing below uses a bench baud16 that toggles every 2 clk, so one tick = 4 clk and one bit = 64 clk.

1. Reset: assert rst for 3 cycles mid-operation, then release -> txd=1, tx_ready=1, busy=0, tx_done=0 on the cycle after the release edge.
2. Send 0x55 (no parity), tx_valid held 1 cycle:
   - txd sequence: 0, then 1,0,1,0,1,0,1,0, then 1; each level held 64 clk ±4.
   - tx_done pulses once, 640 clk ±4 after accept.
3. Back-to-back 0xA3 then 0x0F, tx_valid held high throughout:
   - second accept occurs exactly 1 cycle after the first tx_done;
   - second frame data bits are 1,1,1,1,0,0,0,0;
   - the tx_data change during the first frame does not corrupt it.
4. UART_TX_PARITY_EN defined, send 0x07 -> parity bit = 1; send 0x03 -> parity bit = 0; each frame is 11 bits = 704 clk ±4 to tx_done.
5. Reset during data bit 3 of 0xFF -> txd=1 on the next cycle, tx_ready=1, no tx_done. A subsequent 0x81 frame is correct.
6. Hold baud16 low for 1000 clk during data bit 2 -> txd and the internal state stay constant. After resume, the remaining bits complete with correct 16-tick durations.
